// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO: pointer-width helper and
// the status bundle that mirrors the flag outputs.
package fifo_pkg;

    // One extra pointer bit distinguishes full from empty when the low bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH dual-port storage with synchronous write. The read port is
// registered (FWFT=0) or a combinational view of the addressed entry (FWFT=1).
module fifo_mem #(
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 8,
    parameter  int FWFT       = 0,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata_o = mem_q[raddr_i];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_v3.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, fill
// count, sticky overflow/underflow flags and optional first-word-fall-through.
module sync_fifo_v3
    import fifo_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 8,
    parameter  int AF_THRESH  = DEPTH - 2,
    parameter  int AE_THRESH  = 2,
    parameter  int FWFT       = 0,
    localparam int PTR_W      = ptr_w(DEPTH),
    localparam int CNT_W      = PTR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int ADDR_W = PTR_W - 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_v3: DEPTH must be a power of 2 and at least 2");
        end
        if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
            $error("sync_fifo_v3: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;
    fifo_status_t     status;

    // Occupancy falls out of the wrap-bit pointer difference; no separate counter.
    assign count = wr_ptr_q - rd_ptr_q;

    assign status = '{
        full:         (count == CNT_W'(DEPTH)),
        empty:        (count == '0),
        almost_full:  (count >= CNT_W'(AF_THRESH)),
        almost_empty: (count <= CNT_W'(AE_THRESH)),
        overflow:     ovf_q,
        underflow:    unf_q
    };

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

    always_comb begin
        wr_acc   = wren && !status.full;
        rd_acc   = rden && !status.empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
        // A fresh error in the clearing cycle takes priority over clr_err.
        ovf_d    = clr_err ? 1'b0 : ovf_q;
        unf_d    = clr_err ? 1'b0 : unf_q;
        if (wren && status.full) begin
            ovf_d = 1'b1;
        end
        if (rden && status.empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FWFT       (FWFT)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (i_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (o_data)
    );

endmodule

// File: tb/tb_sync_fifo_v3.sv
// Bench for sync_fifo_v3: registered-read instance checked through a read-data
// scoreboard, plus an FWFT instance checked directly.
module tb_sync_fifo_v3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       wren = 1'b0, rden = 1'b0, clr_err = 1'b0;
    logic [7:0] i_data = '0;
    logic [7:0] o_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       wren1 = 1'b0, rden1 = 1'b0, clr_err1 = 1'b0;
    logic [7:0] i_data1 = '0;
    logic [7:0] o_data1;
    logic       full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
    logic [3:0] count1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];
    logic       rd_pend;

    always #5 clk = ~clk;

    sync_fifo_v3 #(.DEPTH(8), .DATA_WIDTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(o_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_v3 #(.DEPTH(8), .DATA_WIDTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wren(wren1), .i_data(i_data1), .rden(rden1),
        .o_data(o_data1), .full(full1), .empty(empty1), .almost_full(almost_full1),
        .almost_empty(almost_empty1), .count(count1), .overflow(overflow1),
        .underflow(underflow1), .clr_err(clr_err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a read accepted at an edge presents data by the following negedge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pend <= 1'b0;
        else        rd_pend <= rden && !empty;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_read: got 0x%0h with no expected entry", o_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL sb_rdata: got 0x%0h expected 0x%0h at %0t", o_data, e, $time);
                end
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wren = w; i_data = d; rden = r; clr_err = c;
        @(posedge clk);
        #1;
        wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    endtask

    task automatic step1(input logic w, input logic [7:0] d, input logic r);
        wren1 = w; i_data1 = d; rden1 = r;
        @(posedge clk);
        #1;
        wren1 = 1'b0; rden1 = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d);
        model_q.push_back(d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic do_read();
        exp_q.push_back(model_q.pop_front());
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_both(input logic [7:0] d);
        exp_q.push_back(model_q.pop_front());
        model_q.push_back(d);
        step(1'b1, d, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] d;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_odata", o_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: fill 0x11..0x88, then drain in order
        for (int k = 1; k <= 8; k++) begin
            do_write(8'(k * 8'h11));
            chk("t1_count", count, k);
            chk("t1_af", almost_full, (k >= 6));
            chk("t1_full", full, (k == 8));
            chk("t1_ae", almost_empty, (k <= 2));
        end
        for (int k = 1; k <= 8; k++) begin
            do_read();
            chk("t1_rd_count", count, 8 - k);
        end
        chk("t1_empty", empty, 1);

        // Test 2: overflow while full with concurrent accepted read, then clear
        for (int k = 1; k <= 8; k++) do_write(8'(k));
        chk("t2_full", full, 1);
        exp_q.push_back(model_q.pop_front());
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        chk("t2_count", count, 7);
        chk("t2_ovf", overflow, 1);
        chk("t2_full_after", full, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_ovf_clr", overflow, 0);
        chk("t2_count_hold", count, 7);
        for (int k = 0; k < 7; k++) do_read();
        chk("t2_empty", empty, 1);

        // Test 3: underflow, then read+write while empty
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_unf", underflow, 1);
        chk("t3_odata_hold", o_data, 8'h08);
        chk("t3_count", count, 0);
        model_q.push_back(8'h5A);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("t3_unf_stays", underflow, 1);
        chk("t3_count1", count, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_unf_clr", underflow, 0);
        do_read();
        chk("t3_empty", empty, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t3_err_beats_clr", underflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_unf_clr2", underflow, 0);

        // Test 4: steady-state read+write at count=4 across pointer wraps
        d = 8'h20;
        for (int k = 0; k < 4; k++) begin
            do_write(d);
            d++;
        end
        for (int k = 0; k < 20; k++) begin
            do_both(d);
            d++;
            chk("t4_count", count, 4);
        end
        for (int k = 0; k < 4; k++) do_read();
        chk("t4_empty", empty, 1);

        // Test 5: FWFT instance shows head word without a read
        chk("t5_empty0", empty1, 1);
        step1(1'b1, 8'hA5, 1'b0);
        chk("t5_odata", o_data1, 8'hA5);
        chk("t5_count", count1, 1);
        step1(1'b1, 8'h3C, 1'b0);
        chk("t5_head_hold", o_data1, 8'hA5);
        step1(1'b0, 8'h00, 1'b1);
        chk("t5_next_head", o_data1, 8'h3C);
        step1(1'b0, 8'h00, 1'b1);
        chk("t5_empty", empty1, 1);
        chk("t5_count0", count1, 0);

        // Test 6: asynchronous reset mid-burst
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_unf_pre", underflow, 1);
        for (int k = 0; k < 5; k++) do_write(8'(8'hC0 + k));
        chk("t6_count5", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count0", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_unf", underflow, 0);
        chk("t6_ae", almost_empty, 1);
        chk("t6_odata", o_data, 0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_write(8'h77);
        chk("t6_count1", count, 1);
        do_read();
        chk("t6_empty_end", empty, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
